// File: rtl/tone_pkg.sv
// Shared constants for the buzzer tone family: FSM encoding, mode codes and
// the nominal period / tolerance / timeout calculation used by driver and decoder.
package tone_pkg;

   typedef enum logic [1:0] {
      SILENT = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_BASE    = 2'd1;
   localparam logic [1:0] MODE_HALF    = 2'd2;
   localparam logic [1:0] MODE_QUARTER = 2'd3;

   localparam int unsigned SEL_PERIOD  = 0;
   localparam int unsigned SEL_TOL     = 1;
   localparam int unsigned SEL_TIMEOUT = 2;

   // Mode k has period HALF_PERIOD << k, so a left shift by the mode code gives Pk.
   function automatic logic [63:0] tone_const(input logic [63:0] half_period,
                                              input int unsigned tol_shift,
                                              input int unsigned sel,
                                              input logic [1:0]  mode);
      logic [63:0] p;
      logic [63:0] p3;
      logic [63:0] result;
      p  = half_period << mode;
      p3 = half_period << 3;
      case (sel)
         SEL_PERIOD: result = p;
         SEL_TOL:    result = p >> tol_shift;
         default:    result = p3 + (p3 >> tol_shift) + 64'd1;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer followed by a registered one-cycle rising-edge pulse.
module sync_rise (
   input  logic clk,
   input  logic RSTn,
   input  logic d,
   output logic rise
);

   logic sync_p0;
   logic sync_p1;

   // rise is taken from the first two stages so it appears one edge after sync_p0 sees the high
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
         rise    <= sync_p0 & ~sync_p1;
      end
   end

endmodule

// File: rtl/tone_decoder.sv
// Measures the rising-edge period of tone_i and decodes it back to the 2-bit
// buzzer mode that would have generated it.
module tone_decoder
   import tone_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 50000001,
   parameter int unsigned TOL_SHIFT   = 4,
   parameter int unsigned CNT_W       = 30
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic             tone_i,
   output logic [7:0]       mode_o,
   output logic             locked_o,
   output logic             change_o,
   output logic             err_o,
   output logic [CNT_W-1:0] period_o
);

   localparam logic [63:0] HP = 64'(HALF_PERIOD);

   localparam logic [CNT_W-1:0] P1 = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_PERIOD, MODE_BASE));
   localparam logic [CNT_W-1:0] P2 = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_PERIOD, MODE_HALF));
   localparam logic [CNT_W-1:0] P3 = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_PERIOD, MODE_QUARTER));
   localparam logic [CNT_W-1:0] T1 = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_TOL, MODE_BASE));
   localparam logic [CNT_W-1:0] T2 = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_TOL, MODE_HALF));
   localparam logic [CNT_W-1:0] T3 = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_TOL, MODE_QUARTER));
   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(tone_const(HP, TOL_SHIFT, SEL_TIMEOUT, MODE_OFF));

   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] p_meas;
   logic             match;
   logic [1:0]       match_mode;
   logic [1:0]       mode_q;
   state_e           state;

   sync_rise u_sync_rise (
      .clk  (clk),
      .RSTn (RSTn),
      .d    (tone_i),
      .rise (rise)
   );

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= '0;
      end else if (cnt != TIMEOUT) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign p_meas = cnt + CNT_W'(1);

   // Windows cannot overlap for TOL_SHIFT >= 2, so priority order is irrelevant.
   always_comb begin
      match      = 1'b0;
      match_mode = MODE_OFF;
      if (p_meas >= P1 - T1 && p_meas <= P1 + T1) begin
         match      = 1'b1;
         match_mode = MODE_BASE;
      end else if (p_meas >= P2 - T2 && p_meas <= P2 + T2) begin
         match      = 1'b1;
         match_mode = MODE_HALF;
      end else if (p_meas >= P3 - T3 && p_meas <= P3 + T3) begin
         match      = 1'b1;
         match_mode = MODE_QUARTER;
      end
   end

   // rise takes precedence over timeout; a saturated count never matches, so that case errors.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state    <= SILENT;
         mode_q   <= MODE_OFF;
         locked_o <= 1'b0;
         change_o <= 1'b0;
         err_o    <= 1'b0;
         period_o <= '0;
      end else begin
         change_o <= 1'b0;
         err_o    <= 1'b0;
         case (state)
            SILENT: begin
               if (rise) state <= ARMED;
            end
            ARMED, LOCKED: begin
               if (rise) begin
                  period_o <= p_meas;
                  if (match) begin
                     state    <= LOCKED;
                     locked_o <= 1'b1;
                     mode_q   <= match_mode;
                     change_o <= (match_mode != mode_q);
                  end else begin
                     state    <= ARMED;
                     locked_o <= 1'b0;
                     err_o    <= 1'b1;
                  end
               end else if (cnt == TIMEOUT) begin
                  state    <= SILENT;
                  locked_o <= 1'b0;
                  mode_q   <= MODE_OFF;
                  change_o <= (mode_q != MODE_OFF);
               end
            end
            default: begin
               state    <= SILENT;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

   assign mode_o = {6'b0, mode_q};

endmodule
